prince_sbox_cms_pipe: RTL and testbench
=======================================

Name: prince_sbox_cms_pipe

Overview:
- Parametrised, pipelined, first-order CMS-masked PRINCE S-box layer with NUM_SBOX parallel 4-bit channels.
- Each channel takes 2 input shares and expands into 16 share domains, one per input share-index tuple.
- The 16 domain results are registered, then refreshed with fresh randomness and compressed back to 2 output shares.
- Sits between the PRINCE key/round-constant addition and the linear M layer; supersedes the per-bit combinational share-function modules.

Parameters:
- NUM_SBOX, 16, number of parallel S-box channels (1..16).
- Derived, not overridable: DATA_W = 4*NUM_SBOX; RAND_W = 64*NUM_SBOX.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  stage 1 can accept a beat.
- share0_i  in  DATA_W  input share 0; channel c occupies bits [4c+3:4c].
- share1_i  in  DATA_W  input share 1; same layout.
- rand_i  in  RAND_W  fresh randomness; sampled only when stage 1 advances into stage 2.
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  downstream accepts the output beat.
- share0_o  out  DATA_W  output share 0.
- share1_o  out  DATA_W  output share 1.

Behaviour:
- Unmasked function per channel: S = {B,F,3,2,A,C,9,1,6,7,8,0,E,5,D,4}, indexed by nibble value. Input value = share0 ^ share1; output value = share0_o ^ share1_o.
- Domain expansion (stage 1 input, combinational):
  - Domain index k = {a3,a2,a1,a0}; ai selects the share used for nibble bit i.
  - Each ANF monomial of each output bit is evaluated once per share combination of its present variables.
  - The term goes into the domain whose indices match those shares, with index 0 for every absent variable. Each share-product therefore appears in exactly one domain.
  - Non-completeness: domain k sees only one share of each variable.
- Stage 1 register D1: 16 domains x 4 bits per channel, plus valid v1.
- Stage 2 register D2: compressed shares plus valid v2.
  - share0 = XOR of domains 0..7 ^ refresh.
  - share1 = XOR of domains 8..15 ^ refresh.
  - Ring refresh: domain k is XORed with r[k] ^ r[(k+1) mod 16] before compression. r[k] is the 4-bit slice rand_i[64c+4k+3 : 64c+4k].
  - Refresh masks are applied inside D1 -> D2 logic only; they cancel in the total sum.
- Handshake:
  - Stage 2 advances when !v2 || out_ready_i.
  - in_ready_o = !v1 || stage-2-advance, combinational.
  - Input transfer on in_valid_i && in_ready_o.
  - Latency: 2 cycles, input acceptance to out_valid_o. Throughput 1 beat/cycle when out_ready_i is held high.
- Stall: with out_valid_o high and out_ready_i low:
  - share0_o and share1_o stay stable.
  - D1 holds its content; rand_i is ignored.
  - in_ready_o is low when v1 is set.
- Simultaneous accept and drain in the same cycle is legal and loses no beat.
- Reset:
  - All data registers clear to 0; v1 and v2 clear to 0, so out_valid_o = 0 and in_ready_o = 1 after reset.
  - Reset asserted mid-operation discards any in-flight beats immediately (asynchronous).
- Glitch hygiene: no logic path mixes both shares of a variable before the D1 register.

Optional Feature:
- Macro PRINCE_CMS_INV_EN.
- When defined:
  - Adds port inv_i (in, 1), sampled with each input beat.
  - inv_i selects the inverse S-box {B,7,3,2,F,D,8,9,A,6,4,0,5,E,C,1}, using its own ANF with the same domain-assignment rule.
  - inv_i is public, not masked; it travels with the beat through D1.
- When undefined: port absent; forward S-box only.

Decomposition:
- Package prince_cms_pkg holds:
  - S-box and inverse S-box tables.
  - ANF monomial masks per output bit.
  - NUM_DOMAINS = 16, RAND_PER_SBOX = 64.
  - Function domain_of(monomial, share tuple).
- Sub-module prince_cms_domain computes one channel's 16 domain outputs (combinational). The top instantiates it NUM_SBOX times and owns all registers, refresh and handshake.

Test Plan:
- After reset, NUM_SBOX=1: shares (0,0), rand 0, out_ready_i=1 -> out_valid_o exactly 2 cycles later; share0_o ^ share1_o = 0xB.
- Value 5 split as (0x9,0xC) with random rand_i -> XOR of output shares = 0xC. Repeat over all 16 values with 100 random splits each; results must match the table.
- Same input beat with rand_i = 0 versus random rand_i -> identical unmasked output; individual shares differ when rand_i differs.
- out_ready_i low for 5 cycles with 3 beats offered:
  - Two beats held, in_ready_o = 0, outputs stable.
  - On release, beats drain in order with no loss or duplication.
- Assert rst_n low while v1 = v2 = 1 -> out_valid_o = 0 immediately and all outputs 0; the first post-reset beat is accepted on the next cycle.
- With PRINCE_CMS_INV_EN: inv_i=1 with value 0xB -> 0x0; alternate inv_i per beat back-to-back -> each output uses the correct table.

Source files
------------

// File: rtl/prince_cms_pkg.sv
// Shared constants for the masked PRINCE S-box layer: S-box tables, ANF masks
// derived from them, and the share-domain assignment rule.
package prince_cms_pkg;

    localparam int NUM_DOMAINS   = 16;
    localparam int RAND_PER_SBOX = 64;

    // Nibble x of a table lives at bits [4x+3:4x].
    localparam logic [63:0] SBOX_TAB = 64'h4D5E087619CA23FB;
    localparam logic [63:0] SINV_TAB = 64'h1CE5046A98DF237B;

    // Moebius transform of one output bit: bit m of the result is the ANF
    // coefficient of the monomial whose variable set is m.
    function automatic logic [15:0] anf_mask(input logic [63:0] tab, input int bit_i);
        logic [15:0] f;
        for (int x = 0; x < 16; x++)
            f[x] = tab[4*x + bit_i];
        for (int i = 0; i < 4; i++)
            for (int x = 0; x < 16; x++)
                if (((x >> i) & 1) == 1)
                    f[x] = f[x] ^ f[x ^ (1 << i)];
        return f;
    endfunction

    localparam logic [3:0][15:0] ANF_FWD = {anf_mask(SBOX_TAB, 3), anf_mask(SBOX_TAB, 2),
                                            anf_mask(SBOX_TAB, 1), anf_mask(SBOX_TAB, 0)};
    localparam logic [3:0][15:0] ANF_INV = {anf_mask(SINV_TAB, 3), anf_mask(SINV_TAB, 2),
                                            anf_mask(SINV_TAB, 1), anf_mask(SINV_TAB, 0)};

    // Absent variables take share index 0, so the domain is the tuple masked
    // down to the monomial's variables.
    function automatic logic [3:0] domain_of(input logic [3:0] mono, input logic [3:0] tup);
        return tup & mono;
    endfunction

endpackage

// File: rtl/prince_cms_domain.sv
// One channel of CMS domain expansion: 16 share domains of a 4-bit S-box.
// With PRINCE_CMS_INV_EN defined, inv_i selects the inverse S-box ANF.
module prince_cms_domain
    import prince_cms_pkg::*;
(
`ifdef PRINCE_CMS_INV_EN
    input  logic                         inv_i,
`endif
    input  logic [3:0]                   share0_i,
    input  logic [3:0]                   share1_i,
    output logic [NUM_DOMAINS-1:0][3:0]  dom_o
);

    logic             inv_sel;
    logic [3:0][15:0] anf_sel;

`ifdef PRINCE_CMS_INV_EN
    assign inv_sel = inv_i;
`else
    assign inv_sel = 1'b0;
`endif

    // Domain k only ever reads share k[i] of variable i.
    function automatic logic share_prod(input logic [3:0] mono, input logic [3:0] dom,
                                        input logic [3:0] s0, input logic [3:0] s1);
        logic p;
        p = 1'b1;
        for (int i = 0; i < 4; i++)
            if (mono[i])
                p = p & (dom[i] ? s1[i] : s0[i]);
        return p;
    endfunction

    always_comb begin
        anf_sel = inv_sel ? ANF_INV : ANF_FWD;
        dom_o   = '0;
        for (int k = 0; k < NUM_DOMAINS; k++)
            for (int j = 0; j < 4; j++)
                for (int m = 0; m < 16; m++)
                    if (anf_sel[j][m] && (domain_of(4'(m), 4'(k)) == 4'(k)))
                        dom_o[k][j] = dom_o[k][j] ^ share_prod(4'(m), 4'(k), share0_i, share1_i);
    end

endmodule

// File: rtl/prince_sbox_cms_pipe.sv
// Two-stage first-order CMS-masked PRINCE S-box layer with valid/ready flow.
// Optional inverse S-box selection via PRINCE_CMS_INV_EN.
module prince_sbox_cms_pipe
    import prince_cms_pkg::*;
#(
    parameter  int NUM_SBOX = 16,
    localparam int DATA_W   = 4 * NUM_SBOX,
    localparam int RAND_W   = RAND_PER_SBOX * NUM_SBOX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
`ifdef PRINCE_CMS_INV_EN
    input  logic              inv_i,
`endif
    input  logic [DATA_W-1:0] share0_i,
    input  logic [DATA_W-1:0] share1_i,
    input  logic [RAND_W-1:0] rand_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] share0_o,
    output logic [DATA_W-1:0] share1_o
);

    logic [NUM_SBOX-1:0][NUM_DOMAINS-1:0][3:0] dom_c;
    logic [NUM_SBOX-1:0][NUM_DOMAINS-1:0][3:0] d1_q;
    logic                                      v1_q;
    logic                                      v2_q;
    logic [DATA_W-1:0]                         sh0_d, sh1_d;
    logic [DATA_W-1:0]                         sh0_q, sh1_q;
    logic                                      adv2;
    logic                                      accept;

    assign adv2        = !v2_q || out_ready_i;
    assign in_ready_o  = !v1_q || adv2;
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = v2_q;
    assign share0_o    = sh0_q;
    assign share1_o    = sh1_q;

    for (genvar c = 0; c < NUM_SBOX; c++) begin : g_ch
        prince_cms_domain u_dom (
`ifdef PRINCE_CMS_INV_EN
            .inv_i    (inv_i),
`endif
            .share0_i (share0_i[4*c +: 4]),
            .share1_i (share1_i[4*c +: 4]),
            .dom_o    (dom_c[c])
        );
    end

    // Ring refresh: every r[k] enters two neighbouring domains, so the masks
    // cancel in share0 ^ share1 while each half is re-randomised.
    always_comb begin
        sh0_d = '0;
        sh1_d = '0;
        for (int c = 0; c < NUM_SBOX; c++)
            for (int k = 0; k < NUM_DOMAINS; k++) begin
                if (k < NUM_DOMAINS / 2)
                    sh0_d[4*c +: 4] = sh0_d[4*c +: 4] ^ d1_q[c][k]
                                    ^ rand_i[RAND_PER_SBOX*c + 4*k +: 4]
                                    ^ rand_i[RAND_PER_SBOX*c + 4*((k + 1) % NUM_DOMAINS) +: 4];
                else
                    sh1_d[4*c +: 4] = sh1_d[4*c +: 4] ^ d1_q[c][k]
                                    ^ rand_i[RAND_PER_SBOX*c + 4*k +: 4]
                                    ^ rand_i[RAND_PER_SBOX*c + 4*((k + 1) % NUM_DOMAINS) +: 4];
            end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            d1_q  <= '0;
            sh0_q <= '0;
            sh1_q <= '0;
        end else begin
            if (in_ready_o)
                v1_q <= in_valid_i;
            if (accept)
                d1_q <= dom_c;
            if (adv2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    sh0_q <= sh0_d;
                    sh1_q <= sh1_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_prince_sbox_cms_pipe.sv
// Self-checking bench for prince_sbox_cms_pipe (two channels); inverse-table
// checks are compiled in when PRINCE_CMS_INV_EN is defined.
module tb_prince_sbox_cms_pipe;

    localparam int NS = 2;
    localparam int DW = 4 * NS;
    localparam int RW = 64 * NS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic          inv_b = 1'b0;
    logic [DW-1:0] share0_i = '0;
    logic [DW-1:0] share1_i = '0;
    logic [RW-1:0] rand_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b1;
    logic [DW-1:0] share0_o;
    logic [DW-1:0] share1_o;

    prince_sbox_cms_pipe #(.NUM_SBOX(NS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
`ifdef PRINCE_CMS_INV_EN
        .inv_i       (inv_b),
`endif
        .share0_i    (share0_i),
        .share1_i    (share1_i),
        .rand_i      (rand_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .share0_o    (share0_o),
        .share1_o    (share1_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0] FWD [16] = '{4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
                             4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4};
    logic [3:0] INV [16] = '{4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
                             4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1};

    typedef struct {
        logic [DW-1:0] exp;
        int            t;
    } beat_t;
    beat_t q[$];

    bit rnd_rdy  = 1'b0;
    bit rnd_rand = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic inv);
        logic [DW-1:0] r;
        logic [3:0]    v;
        for (int c = 0; c < NS; c++) begin
            v = a[4*c +: 4] ^ b[4*c +: 4];
            r[4*c +: 4] = inv ? INV[v] : FWD[v];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rnd_rdy)  out_ready_i = 1'($urandom_range(0, 1));
        if (rnd_rand) rand_i = {$urandom, $urandom, $urandom, $urandom};
    end

    // Per-cycle compare against the queue model of in-flight beats.
    logic          stall_prev = 1'b0;
    logic [DW-1:0] prev0, prev1;
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            chk("in_ready", in_ready_o, (q.size() < 2) || out_ready_i);
            chk("out_valid", out_valid_o, (q.size() > 0) && (cyc >= q[0].t + 2));
            if (stall_prev && out_valid_o) begin
                chk("stall_hold_s0", share0_o, prev0);
                chk("stall_hold_s1", share1_o, prev1);
            end
            if (out_valid_o && out_ready_i && q.size() > 0) begin
                chk("out_value", share0_o ^ share1_o, q[0].exp);
                void'(q.pop_front());
            end
            stall_prev = out_valid_o && !out_ready_i;
            prev0 = share0_o;
            prev1 = share1_o;
            if (in_valid_i && in_ready_o)
                q.push_back('{exp: model(share0_i, share1_i, inv_b), t: cyc});
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_beat(input logic [DW-1:0] s0, input logic [DW-1:0] s1);
        logic acc;
        acc = 1'b0;
        in_valid_i = 1'b1;
        share0_i   = s0;
        share1_i   = s1;
        for (int i = 0; i < 100; i++) begin
            #1;
            acc = in_ready_o;
            @(negedge clk);
            if (acc) break;
        end
        chk("send_accept", acc, 1'b1);
    endtask

    task automatic capture(output logic [DW-1:0] s0, output logic [DW-1:0] s1);
        logic got;
        got = 1'b0;
        s0 = '0;
        s1 = '0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (out_valid_o) begin
                got = 1'b1;
                s0 = share0_o;
                s1 = share1_o;
            end
            @(negedge clk);
            if (got) break;
        end
        chk("capture_valid", got, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_empty", q.size(), 0);
    endtask

    logic [DW-1:0] a0, a1, b0, b1, rs0, rs1, expdiff;
    logic [RW-1:0] rfix;

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready_o, 1'b1);
        chk("rst_out_valid", out_valid_o, 1'b0);
        chk("rst_share0", share0_o, 8'h00);
        chk("rst_share1", share1_o, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero shares, zero randomness: only the constant term survives, in domain 0.
        in_valid_i = 1'b1;
        share0_i   = '0;
        share1_i   = '0;
        @(negedge clk);
        in_valid_i = 1'b0;
        #1;
        chk("lat_cycle1_valid", out_valid_o, 1'b0);
        @(negedge clk);
        #1;
        chk("lat_cycle2_valid", out_valid_o, 1'b1);
        chk("zero_share0", share0_o, 8'hBB);
        chk("zero_share1", share1_o, 8'h00);
        @(negedge clk);

        // Same beat with rand 0 and with fixed rand: the refresh shows up as r[0]^r[8] per share.
        rand_i = '0;
        send_beat(8'h93, 8'hC6);
        in_valid_i = 1'b0;
        capture(a0, a1);
        chk("value5_r0", a0 ^ a1, 8'hCC);
        rfix = {64'h1111222233334445, 64'h0123456789ABCDEF};
        for (int c = 0; c < NS; c++)
            expdiff[4*c +: 4] = rfix[64*c +: 4] ^ rfix[64*c + 32 +: 4];
        rand_i = rfix;
        send_beat(8'h93, 8'hC6);
        in_valid_i = 1'b0;
        capture(b0, b1);
        chk("value5_rfix", b0 ^ b1, 8'hCC);
        chk("refresh_diff_s0", a0 ^ b0, expdiff);
        chk("refresh_diff_s1", a1 ^ b1, expdiff);
        chk("refresh_diff_lit", expdiff, 8'h78);

        // Backpressure: two beats held, a third refused for five cycles.
        rnd_rand = 1'b1;
        out_ready_i = 1'b0;
        send_beat(8'h12, 8'h34);
        send_beat(8'h56, 8'h78);
        in_valid_i = 1'b1;
        share0_i   = 8'h9A;
        share1_i   = 8'hBC;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_in_ready_low", in_ready_o, 1'b0);
            chk("stall_out_valid_high", out_valid_o, 1'b1);
            @(negedge clk);
        end
        out_ready_i = 1'b1;
        send_beat(8'h9A, 8'hBC);
        in_valid_i = 1'b0;
        drain();
        rnd_rand = 1'b0;

        // Asynchronous reset with both stages full.
        out_ready_i = 1'b0;
        send_beat(8'h0F, 8'hF0);
        send_beat(8'h33, 8'h55);
        in_valid_i = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid_o, 1'b0);
        chk("midrst_share0", share0_o, 8'h00);
        chk("midrst_share1", share1_o, 8'h00);
        chk("midrst_in_ready", in_ready_o, 1'b1);
        q.delete();
        @(negedge clk);
        rst_n       = 1'b1;
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        share0_i    = 8'hA5;
        share1_i    = 8'h3C;
        #1;
        chk("post_rst_in_ready", in_ready_o, 1'b1);
        @(negedge clk);
        in_valid_i = 1'b0;
        drain();

`ifdef PRINCE_CMS_INV_EN
        inv_b = 1'b1;
        send_beat(8'h5A, 8'hE1);
        in_valid_i = 1'b0;
        capture(a0, a1);
        chk("inv_B_to_0", a0 ^ a1, 8'h00);
        for (int i = 0; i < 8; i++) begin
            inv_b = 1'(i & 1);
            send_beat(DW'($urandom), DW'($urandom));
        end
        in_valid_i = 1'b0;
        inv_b = 1'b0;
        drain();
`endif

        // Every value, random splits, random randomness and backpressure.
        rnd_rdy  = 1'b1;
        rnd_rand = 1'b1;
        for (int v = 0; v < 16; v++) begin
            for (int s = 0; s < 100; s++) begin
                rs0 = DW'($urandom);
                rs1 = rs0 ^ {4'(15 - v), 4'(v)};
                send_beat(rs0, rs1);
                if ((s % 17) == 0) begin
                    in_valid_i = 1'b0;
                    @(negedge clk);
                end
            end
        end
        in_valid_i = 1'b0;
        rnd_rdy  = 1'b0;
        out_ready_i = 1'b1;
        rnd_rand = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
